clap_pattern_gen: RTL and testbench
===================================

# clap_pattern_gen

Generates the clap waveform that the clap detector consumes. A one-cycle command produces either one synthetic clap or two. Each clap is a main pulse followed by contact-style bounce, and each sequence ends with a quiet hold-off. The block drives the clap input of the detector, either on-board for self-test or toward a second board, so the fan's single/double control path can be exercised without a microphone.

## Interface
Parameters:
- CLK_DIV, 125: clk cycles per 1 µs tick (125 MHz system clock).
- PULSE_US, 20_000: main clap high time in µs; must be ≥1.
- BOUNCE_CNT, 3: low/high bounce pairs after the main pulse; 0 means no bounce.
- BOUNCE_US, 2_000: length of each bounce low and each bounce high, in µs; must be ≥1.
- GAP_US, 250_000: low time in µs between the end of clap 1 (bounce included) and the start of clap 2; must be ≥1.
- HOLDOFF_US, 600_000: forced low time in µs after the last clap; 0 means skip. Set greater than the detector's 500 ms clap-to-clap window.

Ports:
- clk, in, 1: single clock for all logic.
- reset_p, in, 1: synchronous, active-high reset.
- req_single, in, 1: request one clap; sampled only in IDLE.
- req_double, in, 1: request two claps; sampled only in IDLE.
- abort, in, 1: cuts the sequence short and jumps to HOLDOFF.
- clap, out, 1: generated clap waveform; registered.
- busy, out, 1: high while a sequence is in progress.
- done, out, 1: one-cycle pulse when a sequence completes.

## Operation
- Reset (synchronous, reset_p=1 at a clk edge):
  - clap=0, busy=0, done=0.
  - FSM goes to IDLE; divider and phase counter are cleared.
- FSM states: IDLE, PULSE, BOUNCE_LO, BOUNCE_HI, GAP, HOLDOFF, DONE.
- IDLE:
  - req_double → PULSE with second=1.
  - Otherwise req_single → PULSE with second=0.
  - req_double wins if both are high.
- PULSE: clap=1 for PULSE_US. Then → BOUNCE_LO if BOUNCE_CNT>0, else → END.
- BOUNCE_LO: clap=0 for BOUNCE_US, then → BOUNCE_HI.
- BOUNCE_HI:
  - clap=1 for BOUNCE_US.
  - Bounce counter increments at the end of this phase.
  - When the counter reaches BOUNCE_CNT → END; otherwise → BOUNCE_LO.
- END (decision point, not a state):
  - If second=1: clear second and go → GAP.
  - Otherwise → HOLDOFF, or → DONE if HOLDOFF_US=0.
- GAP: clap=0 for GAP_US, then → PULSE. The bounce counter is cleared on this transition.
- HOLDOFF: clap=0 for HOLDOFF_US, then → DONE.
- DONE: clap=0, busy=1, done=1 for exactly one cycle, then → IDLE.
- busy=1 in every state except IDLE.
- Requests arriving while busy=1 are ignored, not queued.
- abort:
  - In PULSE, BOUNCE_LO, BOUNCE_HI or GAP: clap goes to 0 on the next edge and the FSM enters HOLDOFF with a full HOLDOFF_US, or DONE if HOLDOFF_US=0.
  - In IDLE, HOLDOFF or DONE: no effect.
- Counter widths:
  - Divider: $clog2(CLK_DIV) bits.
  - Phase counter: 24 bits, enough for any phase up to 16.7 s.
  - Bounce counter: 8 bits.

## Timing
- Phase timing base:
  - The divider and phase counter restart on every state entry.
  - A phase of N µs therefore lasts exactly N×CLK_DIV cycles, with no tick-phase jitter.
- Request latency:
  - Request sampled high in IDLE at edge k.
  - clap=1 and busy=1 from cycle k+1.
- Transitions between phases are back-to-back, with no idle cycles between phases.
- Single sequence length: (PULSE_US + 2×BOUNCE_CNT×BOUNCE_US + HOLDOFF_US)×CLK_DIV cycles, plus 1 DONE cycle.
- Double sequence length: the single length plus (GAP_US + PULSE_US + 2×BOUNCE_CNT×BOUNCE_US)×CLK_DIV.
- Back-to-back requests: the cycle after DONE is IDLE, and a request present in that cycle is accepted.
- Reset mid-sequence: clap=0 and busy=0 on the next edge, and no done pulse is produced.

## Test plan
All scenarios use CLK_DIV=2, PULSE_US=4, BOUNCE_CNT=2, BOUNCE_US=1, GAP_US=10, HOLDOFF_US=5. A request is given at cycle 0.
- Single clap: req_single at cycle 0 → expected:
  - clap high in cycles 1–8, low 9–10, high 11–12, low 13–14, high 15–16, low 17–26.
  - done=1 at cycle 27 only; busy=1 over 1–27; busy=0 at 28.
- Double clap: req_double at cycle 0 → expected:
  - Clap 1 pattern in cycles 1–16, as above.
  - Low 17–36.
  - Clap 2 pattern in 37–52.
  - Low 53–62.
  - done at cycle 63.
- Priority and ignore:
  - req_single and req_double both high at cycle 0 → double pattern.
  - req_single pulses at cycles 5 and 40 during that double → no effect on waveform or timing.
- Abort: req_double at cycle 0, abort at cycle 20 (in GAP) → expected:
  - clap stays 0 from 17 onward.
  - HOLDOFF in cycles 21–30; done at cycle 31.
  - No second clap.
- Reset mid-pulse and parameter edge case:
  - reset_p at cycle 4 of a single → clap=0, busy=0 at cycle 5; done never asserted; a new req_single at cycle 6 restarts the full pattern.
  - Rerun the single-clap scenario with BOUNCE_CNT=0 and HOLDOFF_US=0 → clap high 1–8, done at cycle 9.

Source files
------------

// File: rtl/clap_pattern_gen.sv
// clap_pattern_gen: synthetic single/double clap waveform with bounce and hold-off for exercising the clap detector.
module clap_pattern_gen #(
  parameter int CLK_DIV    = 125,
  parameter int PULSE_US   = 20_000,
  parameter int BOUNCE_CNT = 3,
  parameter int BOUNCE_US  = 2_000,
  parameter int GAP_US     = 250_000,
  parameter int HOLDOFF_US = 600_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic req_single,
  input  logic req_double,
  input  logic abort,
  output logic clap,
  output logic busy,
  output logic done
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, PULSE, BOUNCE_LO, BOUNCE_HI, GAP, HOLDOFF, DONE} state_t;
  state_t state_q, state_d, end_st, fin;
  logic [DW-1:0] div_q;
  logic [23:0] ph_q, len;
  logic [7:0] bcnt_q, bcnt_d;
  logic second_q, second_d, clap_q, tick, ph_end;
  assign tick = div_q == DW'(CLK_DIV - 1);
  assign len = state_q == PULSE   ? 24'(PULSE_US - 1) :
               state_q == GAP     ? 24'(GAP_US - 1) :
               state_q == HOLDOFF ? 24'(HOLDOFF_US - 1) : 24'(BOUNCE_US - 1);
  assign ph_end = tick && ph_q == len;
  assign end_st = HOLDOFF_US == 0 ? DONE : HOLDOFF;
  // Where a clap ends: into the gap if a second clap is pending, else wind down.
  assign fin = second_q ? GAP : end_st;
  always_comb begin
    state_d  = state_q;
    second_d = second_q;
    bcnt_d   = bcnt_q;
    unique case (state_q)
      IDLE: if (req_double || req_single) begin
        state_d  = PULSE;
        second_d = req_double;
        bcnt_d   = '0;
      end
      PULSE: if (ph_end) begin
        state_d  = BOUNCE_CNT > 0 ? BOUNCE_LO : fin;
        second_d = BOUNCE_CNT > 0 ? second_q : 1'b0;
      end
      BOUNCE_LO: if (ph_end) state_d = BOUNCE_HI;
      BOUNCE_HI: if (ph_end) begin
        bcnt_d   = bcnt_q + 8'd1;
        state_d  = bcnt_d == 8'(BOUNCE_CNT) ? fin : BOUNCE_LO;
        second_d = bcnt_d == 8'(BOUNCE_CNT) ? 1'b0 : second_q;
      end
      GAP: if (ph_end) begin
        state_d = PULSE;
        bcnt_d  = '0;
      end
      HOLDOFF: if (ph_end) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q inside {PULSE, BOUNCE_LO, BOUNCE_HI, GAP}) begin
      state_d  = end_st;
      second_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= IDLE;
      div_q    <= '0;
      ph_q     <= '0;
      bcnt_q   <= '0;
      second_q <= 1'b0;
      clap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      second_q <= second_d;
      clap_q   <= state_d == PULSE || state_d == BOUNCE_HI;
      // Timebase restarts on every state entry so each phase is exactly N*CLK_DIV cycles.
      if (state_d != state_q || state_q == IDLE) begin
        div_q <= '0;
        ph_q  <= '0;
      end else begin
        div_q <= tick ? '0 : div_q + DW'(1);
        ph_q  <= ph_q + 24'(tick);
      end
    end
  end
  assign clap = clap_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_clap_pattern_gen.sv
// tb_clap_pattern_gen: two configurations checked every cycle against a timeline model, plus literal scenario expectations.
module tb_clap_pattern_gen;
  localparam int D = 2, P = 4, B = 1, G = 10;
  logic clk = 1'b0;
  logic [1:0] rst, rs, rd, ab, cl, bs, dn;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  bit act [2];
  bit dbl [2];
  bit abd [2];
  int t [2];
  int abt [2];
  always #5 clk = ~clk;
  clap_pattern_gen #(.CLK_DIV(2), .PULSE_US(4), .BOUNCE_CNT(2), .BOUNCE_US(1), .GAP_US(10), .HOLDOFF_US(5)) u0 (
    .clk(clk), .reset_p(rst[0]), .req_single(rs[0]), .req_double(rd[0]), .abort(ab[0]),
    .clap(cl[0]), .busy(bs[0]), .done(dn[0]));
  clap_pattern_gen #(.CLK_DIV(2), .PULSE_US(4), .BOUNCE_CNT(0), .BOUNCE_US(1), .GAP_US(10), .HOLDOFF_US(0)) u1 (
    .clk(clk), .reset_p(rst[1]), .req_single(rs[1]), .req_double(rd[1]), .abort(ab[1]),
    .clap(cl[1]), .busy(bs[1]), .done(dn[1]));
  task automatic chk(input string n, input logic a, input logic x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", n, a, x, $time);
    end
  endtask
  function automatic bit cpat(int o, int bc);
    if (o < P * D) return 1'b1;
    return ((o - P * D) / (B * D)) % 2 == 1;
  endfunction
  // Expected {last, abortable, done, busy, clap} at t cycles after acceptance.
  function automatic logic [4:0] mexp(int d, int tt, bit db, bit ad, int at);
    int bc, ho, l, o;
    bc = d == 0 ? 2 : 0;
    ho = d == 0 ? 5 : 0;
    l = (P + 2 * bc * B) * D;
    if (ad && tt >= at) return (tt - at < ho * D) ? 5'b00010 : 5'b10110;
    if (tt < l) return {3'b010, 1'b1, cpat(tt, bc)};
    o = tt - l;
    if (db) begin
      if (o < G * D) return 5'b01010;
      o -= G * D;
      if (o < l) return {3'b010, 1'b1, cpat(o, bc)};
      o -= l;
    end
    return (o < ho * D) ? 5'b00010 : 5'b10110;
  endfunction
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [4:0] e;
      e = mexp(d, t[d], dbl[d], abd[d], abt[d]);
      if (rst[d]) act[d] = 1'b0;
      else if (!act[d]) begin
        if (rs[d] | rd[d]) begin
          act[d] = 1'b1;
          t[d] = 0;
          dbl[d] = rd[d];
          abd[d] = 1'b0;
        end
      end else if (e[4]) act[d] = 1'b0;
      else begin
        if (ab[d] && e[3]) begin
          abd[d] = 1'b1;
          abt[d] = t[d] + 1;
        end
        t[d]++;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [4:0] e;
        e = act[d] ? mexp(d, t[d], dbl[d], abd[d], abt[d]) : 5'b0;
        chk($sformatf("model%0d_clap", d), cl[d], e[0]);
        chk($sformatf("model%0d_busy", d), bs[d], e[1]);
        chk($sformatf("model%0d_done", d), dn[d], e[2]);
      end
    end
  end
  function automatic bit pat(int c);
    return (c >= 1 && c <= 8) || (c >= 11 && c <= 12) || (c >= 15 && c <= 16);
  endfunction
  initial begin
    rst = 2'b11; rs = '0; rd = '0; ab = '0;
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; t[d] = 0; dbl[d] = 0; abd[d] = 0; abt[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_clap", cl[0] | cl[1], 1'b0);
    chk("reset_busy", bs[0] | bs[1], 1'b0);
    chk("reset_done", dn[0] | dn[1], 1'b0);
    chk_en = 1'b1;
    @(posedge clk); #2;
    rst = '0;
    @(posedge clk); #2;
    for (int c = 0; c <= 30; c++) begin
      rs[0] = c == 0;
      @(negedge clk);
      chk("single_clap", cl[0], pat(c));
      chk("single_busy", bs[0], c >= 1 && c <= 27);
      chk("single_done", dn[0], c == 27);
      @(posedge clk); #2;
    end
    for (int c = 0; c <= 66; c++) begin
      rs[0] = c == 0 || c == 5 || c == 40;
      rd[0] = c == 0;
      @(negedge clk);
      chk("double_clap", cl[0], pat(c) || pat(c - 36));
      chk("double_busy", bs[0], c >= 1 && c <= 63);
      chk("double_done", dn[0], c == 63);
      @(posedge clk); #2;
    end
    for (int c = 0; c <= 35; c++) begin
      rd[0] = c == 0;
      ab[0] = c == 20;
      @(negedge clk);
      chk("abort_clap", cl[0], c < 17 && pat(c));
      chk("abort_busy", bs[0], c >= 1 && c <= 31);
      chk("abort_done", dn[0], c == 31);
      @(posedge clk); #2;
    end
    ab[0] = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      rs[0] = c == 0 || c == 6;
      rst[0] = c == 4;
      @(negedge clk);
      chk("rst_clap", cl[0], c < 5 ? pat(c) : pat(c - 6));
      chk("rst_busy", bs[0], (c >= 1 && c <= 4) || (c >= 7 && c <= 33));
      chk("rst_done", dn[0], c == 33);
      @(posedge clk); #2;
    end
    rst[0] = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      rs[1] = c == 0;
      @(negedge clk);
      chk("nob_clap", cl[1], c >= 1 && c <= 8);
      chk("nob_busy", bs[1], c >= 1 && c <= 9);
      chk("nob_done", dn[1], c == 9);
      @(posedge clk); #2;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 2; d++) begin
        rs[d] = $urandom_range(39) == 0;
        rd[d] = $urandom_range(49) == 0;
        ab[d] = $urandom_range(149) == 0;
        rst[d] = $urandom_range(1999) == 0;
      end
      @(posedge clk); #2;
    end
    rs = '0; rd = '0; ab = '0; rst = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
